// File: rtl/udp_tx_arbiter_if.sv
// Handshake and data bundle between the two packet sources, the arbiter and the UDP transmit engine.
// The master modport is the arbiter's view; the slave modport is the sources-plus-engine side.
interface udp_tx_arbiter_if;
    logic        src0_start_en;
    logic [15:0] src0_byte_num;
    logic [31:0] src0_tx_data;
    logic        src0_tx_req;
    logic        src0_tx_done;
    logic        src1_start_en;
    logic [15:0] src1_byte_num;
    logic [31:0] src1_tx_data;
    logic        src1_tx_req;
    logic        src1_tx_done;
    logic        udp_tx_start_en;
    logic [15:0] udp_tx_byte_num;
    logic [31:0] udp_tx_data;
    logic        udp_tx_req;
    logic        udp_tx_done;

    modport master (
        input  src0_start_en, src0_byte_num, src0_tx_data,
        input  src1_start_en, src1_byte_num, src1_tx_data,
        input  udp_tx_req, udp_tx_done,
        output src0_tx_req, src0_tx_done, src1_tx_req, src1_tx_done,
        output udp_tx_start_en, udp_tx_byte_num, udp_tx_data
    );

    modport slave (
        output src0_start_en, src0_byte_num, src0_tx_data,
        output src1_start_en, src1_byte_num, src1_tx_data,
        output udp_tx_req, udp_tx_done,
        input  src0_tx_req, src0_tx_done, src1_tx_req, src1_tx_done,
        input  udp_tx_start_en, udp_tx_byte_num, udp_tx_data
    );
endinterface

// File: rtl/udp_tx_arbiter.sv
// Grants the single UDP transmit engine to one of two packet sources, with request
// queuing, round-robin or fixed selection, an inter-packet gap, a done timeout and drop counting.
module udp_tx_arbiter #(
    parameter int MAX_BYTES      = 1472,
    parameter int GAP_CYCLES     = 12,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic             eth_tx_clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    udp_tx_arbiter_if.master bus,
    output logic             grant,
    output logic             busy,
    output logic [15:0]      drop_cnt,
    output logic             timeout_err
);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, START, BUSY, GAP} state_t;

    state_t           r_state;
    logic [1:0]       r_pend;
    logic [15:0]      r_len [2];
    logic             r_rrPtr;
    logic             r_grant;
    logic             r_busy;
    logic             r_startEn;
    logic             r_timeoutErr;
    logic [15:0]      r_byteNum;
    logic [15:0]      r_dropCnt;
    logic [TMO_W-1:0] r_tmo;
    logic [7:0]       r_gap;

    logic [1:0]  w_start;
    logic [1:0]  w_valid;
    logic [1:0]  w_drop;
    logic [1:0]  w_elig;
    logic [1:0]  w_clr;
    logic [1:0]  w_over;
    logic [15:0] w_byteNum [2];
    logic        w_tie;
    logic        w_pick;
    logic        w_doGrant;
    logic        w_inBusy;
    logic [16:0] w_dropSum;

    assign w_start      = {bus.src1_start_en, bus.src0_start_en};
    assign w_byteNum[0] = bus.src0_byte_num;
    assign w_byteNum[1] = bus.src1_byte_num;

    // A request consumed by this cycle's grant is not an overwrite when a new start arrives alongside it.
    always_comb begin
        w_valid   = '0;
        w_elig    = '0;
        w_clr     = '0;
        w_over    = '0;
        w_drop    = '0;
        w_tie     = 1'b0;
        w_pick    = 1'b0;
        w_doGrant = 1'b0;
        w_dropSum = '0;
        for (int i = 0; i < 2; i++) begin
            w_valid[i] = w_start[i] && (w_byteNum[i] != 16'd0) &&
                         (w_byteNum[i] <= 16'(MAX_BYTES));
        end
        case (mode)
            2'd0:    w_elig = {1'b0, r_pend[0]};
            2'd1:    w_elig = {r_pend[1], 1'b0};
            default: w_elig = r_pend;
        endcase
        w_tie     = mode[1] && (&r_pend);
        w_pick    = w_tie ? r_rrPtr : w_elig[1];
        w_doGrant = (r_state == IDLE) && (|w_elig);
        if (w_doGrant) begin
            w_clr[w_pick] = 1'b1;
        end
        for (int i = 0; i < 2; i++) begin
            w_over[i] = w_valid[i] && r_pend[i] && !w_clr[i];
            w_drop[i] = (w_start[i] && !w_valid[i]) || w_over[i];
        end
        w_dropSum = {1'b0, r_dropCnt} + 17'(w_drop[0]) + 17'(w_drop[1]);
    end

    always_ff @(posedge eth_tx_clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_pend       <= '0;
            r_len[0]     <= '0;
            r_len[1]     <= '0;
            r_rrPtr      <= 1'b0;
            r_grant      <= 1'b0;
            r_busy       <= 1'b0;
            r_startEn    <= 1'b0;
            r_timeoutErr <= 1'b0;
            r_byteNum    <= '0;
            r_dropCnt    <= '0;
            r_tmo        <= '0;
            r_gap        <= '0;
        end else begin
            r_startEn    <= 1'b0;
            r_timeoutErr <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                if (w_valid[i]) begin
                    r_pend[i] <= 1'b1;
                    r_len[i]  <= w_byteNum[i];
                end else if (w_clr[i]) begin
                    r_pend[i] <= 1'b0;
                end
            end
            r_dropCnt <= w_dropSum[16] ? 16'hFFFF : w_dropSum[15:0];

            case (r_state)
                IDLE: begin
                    if (w_doGrant) begin
                        r_grant   <= w_pick;
                        r_byteNum <= r_len[w_pick];
                        r_startEn <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= START;
                        if (w_tie) begin
                            r_rrPtr <= ~r_rrPtr;
                        end
                    end
                end
                START: begin
                    r_tmo   <= '0;
                    r_state <= BUSY;
                end
                BUSY: begin
                    // Engine done wins over a timeout landing in the same cycle.
                    if (bus.udp_tx_done) begin
                        r_gap   <= '0;
                        r_state <= GAP;
                    end else if (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        r_timeoutErr <= 1'b1;
                        r_gap        <= '0;
                        r_state      <= GAP;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                GAP: begin
                    if (r_gap == 8'(GAP_CYCLES - 1)) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_gap <= r_gap + 8'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_inBusy = (r_state == BUSY);

    assign bus.src0_tx_req     = w_inBusy && !r_grant && bus.udp_tx_req;
    assign bus.src1_tx_req     = w_inBusy &&  r_grant && bus.udp_tx_req;
    assign bus.src0_tx_done    = w_inBusy && !r_grant && bus.udp_tx_done;
    assign bus.src1_tx_done    = w_inBusy &&  r_grant && bus.udp_tx_done;
    assign bus.udp_tx_data     = !w_inBusy ? 32'd0 :
                                 (r_grant ? bus.src1_tx_data : bus.src0_tx_data);
    assign bus.udp_tx_start_en = r_startEn;
    assign bus.udp_tx_byte_num = r_byteNum;

    assign grant       = r_grant;
    assign busy        = r_busy;
    assign drop_cnt    = r_dropCnt;
    assign timeout_err = r_timeoutErr;
endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Directed bench for udp_tx_arbiter: one instance with default parameters and a
// second with a 64-cycle done timeout for the abort path.
module tb_udp_tx_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mode;
    logic [1:0]  modeTo;
    logic        grant, busy, timeoutErr;
    logic        grantTo, busyTo, timeoutErrTo;
    logic [15:0] dropCnt, dropCntTo;
    int          cmpCount;
    int          errCount;
    int          cyc;

    always #5 clk = ~clk;

    udp_tx_arbiter_if bus();
    udp_tx_arbiter_if busTo();

    udp_tx_arbiter dut (
        .eth_tx_clk (clk),
        .rst        (rst),
        .mode       (mode),
        .bus        (bus),
        .grant      (grant),
        .busy       (busy),
        .drop_cnt   (dropCnt),
        .timeout_err(timeoutErr)
    );

    udp_tx_arbiter #(.TIMEOUT_CYCLES(64)) dutTo (
        .eth_tx_clk (clk),
        .rst        (rst),
        .mode       (modeTo),
        .bus        (busTo),
        .grant      (grantTo),
        .busy       (busyTo),
        .drop_cnt   (dropCntTo),
        .timeout_err(timeoutErrTo)
    );

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        cmpCount++;
        assert (observed === expected) else begin
            errCount++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    // One-cycle start pulse on the main instance; returns one cycle after the pulse.
    task automatic applyStimulus(input logic src, input logic [15:0] len);
        if (src) begin
            bus.src1_start_en = 1'b1;
            bus.src1_byte_num = len;
        end else begin
            bus.src0_start_en = 1'b1;
            bus.src0_byte_num = len;
        end
        step();
        bus.src0_start_en = 1'b0;
        bus.src1_start_en = 1'b0;
    endtask

    // Engine done n cycles from now; returns in the IDLE decision cycle 13 cycles after done.
    task automatic finishPacket(input int n, input logic g);
        repeat (n) step();
        bus.udp_tx_done = 1'b1;
        #1;
        checkOutput("done_routed", g ? bus.src1_tx_done : bus.src0_tx_done, 1);
        checkOutput("done_other",  g ? bus.src0_tx_done : bus.src1_tx_done, 0);
        step();
        bus.udp_tx_done = 1'b0;
        bus.udp_tx_req  = 1'b1;
        #1;
        checkOutput("req_ignored_gap", bus.src0_tx_req | bus.src1_tx_req, 0);
        checkOutput("data_zero_gap", bus.udp_tx_data, 0);
        bus.udp_tx_req = 1'b0;
        repeat (11) step();
        checkOutput("gap_busy_high", busy, 1);
        step();
        checkOutput("gap_busy_low", busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: observed no $finish, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        cmpCount = 0;
        errCount = 0;
        cyc      = 0;
        rst      = 1'b1;
        mode     = 2'd2;
        modeTo   = 2'd2;
        bus.src0_start_en = 1'b0; bus.src0_byte_num = '0; bus.src0_tx_data = 32'hDEADBEEF;
        bus.src1_start_en = 1'b0; bus.src1_byte_num = '0; bus.src1_tx_data = 32'hCAFEF00D;
        bus.udp_tx_req    = 1'b0; bus.udp_tx_done   = 1'b0;
        busTo.src0_start_en = 1'b0; busTo.src0_byte_num = '0; busTo.src0_tx_data = '0;
        busTo.src1_start_en = 1'b0; busTo.src1_byte_num = '0; busTo.src1_tx_data = '0;
        busTo.udp_tx_req    = 1'b0; busTo.udp_tx_done   = 1'b0;
        repeat (3) step();

        checkOutput("rst_start_en", bus.udp_tx_start_en, 0);
        checkOutput("rst_byte_num", bus.udp_tx_byte_num, 0);
        checkOutput("rst_data", bus.udp_tx_data, 0);
        checkOutput("rst_grant", grant, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_drop_cnt", dropCnt, 0);
        checkOutput("rst_timeout", timeoutErr, 0);
        rst = 1'b0;

        // Single src0 packet, engine done 300 cycles after the start pulse.
        step();
        applyStimulus(1'b0, 16'd1024);
        checkOutput("t1_no_start_yet", bus.udp_tx_start_en, 0);
        checkOutput("t1_idle_busy", busy, 0);
        step();
        checkOutput("t1_start_en", bus.udp_tx_start_en, 1);
        checkOutput("t1_byte_num", bus.udp_tx_byte_num, 1024);
        checkOutput("t1_grant", grant, 0);
        checkOutput("t1_busy", busy, 1);
        checkOutput("t1_data_zero_start", bus.udp_tx_data, 0);
        step();
        checkOutput("t1_start_once", bus.udp_tx_start_en, 0);
        bus.udp_tx_req   = 1'b1;
        bus.src0_tx_data = 32'h11223344;
        bus.src1_tx_data = 32'h55667788;
        #1;
        checkOutput("t1_req_src0", bus.src0_tx_req, 1);
        checkOutput("t1_req_src1", bus.src1_tx_req, 0);
        checkOutput("t1_data_mux", bus.udp_tx_data, 32'h11223344);
        bus.udp_tx_req = 1'b0;
        repeat (298) step();
        finishPacket(1, 1'b0);

        // Simultaneous requests in round-robin: order alternates between the two rounds.
        bus.src0_start_en = 1'b1; bus.src0_byte_num = 16'd100;
        bus.src1_start_en = 1'b1; bus.src1_byte_num = 16'd200;
        step();
        bus.src0_start_en = 1'b0; bus.src1_start_en = 1'b0;
        step();
        checkOutput("t2a_start", bus.udp_tx_start_en, 1);
        checkOutput("t2a_grant", grant, 0);
        checkOutput("t2a_len", bus.udp_tx_byte_num, 100);
        finishPacket(5, 1'b0);
        checkOutput("t2a_no_early_start", bus.udp_tx_start_en, 0);
        step();
        checkOutput("t2a_second_start_14", bus.udp_tx_start_en, 1);
        checkOutput("t2a_second_grant", grant, 1);
        checkOutput("t2a_second_len", bus.udp_tx_byte_num, 200);
        finishPacket(5, 1'b1);

        bus.src0_start_en = 1'b1; bus.src0_byte_num = 16'd300;
        bus.src1_start_en = 1'b1; bus.src1_byte_num = 16'd400;
        step();
        bus.src0_start_en = 1'b0; bus.src1_start_en = 1'b0;
        step();
        checkOutput("t2b_start", bus.udp_tx_start_en, 1);
        checkOutput("t2b_grant_alt", grant, 1);
        checkOutput("t2b_len", bus.udp_tx_byte_num, 400);
        finishPacket(5, 1'b1);
        checkOutput("t2b_no_early_start", bus.udp_tx_start_en, 0);
        step();
        checkOutput("t2b_second_start", bus.udp_tx_start_en, 1);
        checkOutput("t2b_second_grant", grant, 0);
        checkOutput("t2b_second_len", bus.udp_tx_byte_num, 300);
        finishPacket(5, 1'b0);

        // Mode 1 serves only src1; src0 stays pending until mode 0.
        mode = 2'd1;
        bus.src0_start_en = 1'b1; bus.src0_byte_num = 16'd50;
        bus.src1_start_en = 1'b1; bus.src1_byte_num = 16'd60;
        step();
        bus.src0_start_en = 1'b0; bus.src1_start_en = 1'b0;
        step();
        checkOutput("t3_start", bus.udp_tx_start_en, 1);
        checkOutput("t3_grant", grant, 1);
        checkOutput("t3_len", bus.udp_tx_byte_num, 60);
        finishPacket(4, 1'b1);
        step();
        checkOutput("t3_src0_blocked", bus.udp_tx_start_en, 0);
        checkOutput("t3_idle", busy, 0);
        mode = 2'd0;
        step();
        checkOutput("t3_mode0_start", bus.udp_tx_start_en, 1);
        checkOutput("t3_mode0_grant", grant, 0);
        checkOutput("t3_mode0_len", bus.udp_tx_byte_num, 50);
        finishPacket(4, 1'b0);
        checkOutput("t3_no_drops", dropCnt, 0);

        // Drop accounting on src1 while it is held off by mode 0.
        bus.src1_start_en = 1'b1; bus.src1_byte_num = 16'd0;
        step();
        bus.src1_byte_num = 16'd1500;
        step();
        bus.src1_byte_num = 16'd700;
        step();
        bus.src1_byte_num = 16'd900;
        step();
        bus.src1_start_en = 1'b0;
        checkOutput("t4_drop_3", dropCnt, 3);
        checkOutput("t4_held", busy, 0);
        mode = 2'd1;
        step();
        checkOutput("t4_start", bus.udp_tx_start_en, 1);
        checkOutput("t4_last_len", bus.udp_tx_byte_num, 900);
        checkOutput("t4_grant", grant, 1);
        step();
        bus.src0_start_en = 1'b1; bus.src0_byte_num = 16'd1473;
        step();
        bus.src0_byte_num = 16'd1472;
        step();
        bus.src0_start_en = 1'b0;
        bus.src1_start_en = 1'b1; bus.src1_byte_num = 16'd333;
        step();
        bus.src0_start_en = 1'b1; bus.src0_byte_num = 16'd0;
        bus.src1_byte_num = 16'd2000;
        step();
        bus.src0_start_en = 1'b0; bus.src1_start_en = 1'b0;
        checkOutput("t4_drop_6", dropCnt, 6);
        finishPacket(1, 1'b1);
        step();
        checkOutput("t4_busy_capture_start", bus.udp_tx_start_en, 1);
        checkOutput("t4_busy_capture_grant", grant, 1);
        checkOutput("t4_busy_capture_len", bus.udp_tx_byte_num, 333);
        finishPacket(2, 1'b1);
        mode = 2'd0;
        step();
        checkOutput("t4_max_start", bus.udp_tx_start_en, 1);
        checkOutput("t4_max_grant", grant, 0);
        checkOutput("t4_max_len", bus.udp_tx_byte_num, 1472);
        finishPacket(2, 1'b0);

        // Timeout instance: no engine done, abort after 64 BUSY cycles.
        busTo.src1_start_en = 1'b1; busTo.src1_byte_num = 16'd64;
        step();
        busTo.src1_start_en = 1'b0;
        step();
        checkOutput("t5_start", busTo.udp_tx_start_en, 1);
        checkOutput("t5_grant", grantTo, 1);
        repeat (64) step();
        checkOutput("t5_no_early_timeout", timeoutErrTo, 0);
        checkOutput("t5_busy_cycle64", busyTo, 1);
        step();
        checkOutput("t5_timeout_pulse", timeoutErrTo, 1);
        checkOutput("t5_no_done1", busTo.src1_tx_done, 0);
        busTo.udp_tx_done = 1'b1;
        #1;
        checkOutput("t5_done_ignored_gap", busTo.src1_tx_done | busTo.src0_tx_done, 0);
        step();
        busTo.udp_tx_done = 1'b0;
        checkOutput("t5_timeout_once", timeoutErrTo, 0);
        repeat (10) step();
        checkOutput("t5_gap_busy", busyTo, 1);
        step();
        checkOutput("t5_idle", busyTo, 0);

        // Reset mid-BUSY with both requests pending.
        mode = 2'd2;
        applyStimulus(1'b0, 16'd10);
        step();
        checkOutput("t6_start", bus.udp_tx_start_en, 1);
        checkOutput("t6_len", bus.udp_tx_byte_num, 10);
        step();
        bus.src0_start_en = 1'b1; bus.src0_byte_num = 16'd20;
        bus.src1_start_en = 1'b1; bus.src1_byte_num = 16'd30;
        step();
        bus.src0_start_en = 1'b0; bus.src1_start_en = 1'b0;
        bus.udp_tx_req  = 1'b1;
        bus.udp_tx_done = 1'b1;
        rst = 1'b1;
        step();
        checkOutput("t6_rst_start_en", bus.udp_tx_start_en, 0);
        checkOutput("t6_rst_byte_num", bus.udp_tx_byte_num, 0);
        checkOutput("t6_rst_data", bus.udp_tx_data, 0);
        checkOutput("t6_rst_grant", grant, 0);
        checkOutput("t6_rst_busy", busy, 0);
        checkOutput("t6_rst_drop_cnt", dropCnt, 0);
        checkOutput("t6_rst_req", bus.src0_tx_req | bus.src1_tx_req, 0);
        checkOutput("t6_rst_done", bus.src0_tx_done | bus.src1_tx_done, 0);
        rst = 1'b0;
        bus.udp_tx_req  = 1'b0;
        bus.udp_tx_done = 1'b0;
        repeat (6) step();
        checkOutput("t6_pend_discarded_start", bus.udp_tx_start_en, 0);
        checkOutput("t6_pend_discarded_busy", busy, 0);
        applyStimulus(1'b1, 16'd77);
        step();
        checkOutput("t6_fresh_start", bus.udp_tx_start_en, 1);
        checkOutput("t6_fresh_grant", grant, 1);
        checkOutput("t6_fresh_len", bus.udp_tx_byte_num, 77);
        finishPacket(3, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
        $finish;
    end
endmodule
